// File: rtl/sys_ctrl.sv
// UART command decoder: register writes/reads, ALU operations and TX FIFO responses; all outputs registered.
// Optional macro SYS_CTRL_BAD_CMD_ECHO_EN answers an unrecognised command byte with a single 0xEE push.
module sys_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FUNC_WIDTH = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
  input  logic                    RX_D_VLD,
  output logic [ADDR_WIDTH-1:0]   RF_ADDR,
  output logic [DATA_WIDTH-1:0]   RF_WR_DATA,
  output logic                    RF_WR_EN,
  output logic                    RF_RD_EN,
  input  logic [DATA_WIDTH-1:0]   RF_RD_DATA,
  input  logic                    RF_RD_DATA_VLD,
  output logic [FUNC_WIDTH-1:0]   ALU_FUNC,
  output logic                    ALU_EN,
  output logic                    ALU_CLK_EN,
  input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
  input  logic                    ALU_OUT_VLD,
  output logic [DATA_WIDTH-1:0]   FIFO_WR_DATA,
  output logic                    FIFO_WR_INC,
  input  logic                    FIFO_FULL
);

  localparam logic [DATA_WIDTH-1:0] CMD_WR      = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] CMD_RD      = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] CMD_ALU_OP  = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] CMD_ALU_NOP = DATA_WIDTH'(8'hDD);
`ifdef SYS_CTRL_BAD_CMD_ECHO_EN
  localparam logic [DATA_WIDTH-1:0] BAD_CMD_ECHO = DATA_WIDTH'(8'hEE);
`endif

  typedef enum logic [3:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B,
    ALU_FN, ALU_WAIT, TX_BYTE, TX_LO, TX_HI
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   rf_addr_q, rf_addr_d;
  logic [DATA_WIDTH-1:0]   rf_wr_data_q, rf_wr_data_d;
  logic                    rf_wr_en_q, rf_wr_en_d;
  logic                    rf_rd_en_q, rf_rd_en_d;
  logic [FUNC_WIDTH-1:0]   alu_func_q, alu_func_d;
  logic                    alu_en_q, alu_en_d;
  logic                    alu_clk_en_q, alu_clk_en_d;
  logic [DATA_WIDTH-1:0]   fifo_wr_data_q, fifo_wr_data_d;
  logic                    fifo_wr_inc_q, fifo_wr_inc_d;
  logic [DATA_WIDTH-1:0]   tx_byte_q, tx_byte_d;
  logic [2*DATA_WIDTH-1:0] result_q, result_d;
  logic                    can_push;

  // The extra term keeps a push from landing in the cycle right after another one.
  assign can_push = !FIFO_FULL && !fifo_wr_inc_q;

  always_comb begin
    state_d        = state_q;
    rf_addr_d      = rf_addr_q;
    rf_wr_data_d   = rf_wr_data_q;
    rf_wr_en_d     = 1'b0;
    rf_rd_en_d     = 1'b0;
    alu_func_d     = alu_func_q;
    alu_en_d       = 1'b0;
    alu_clk_en_d   = 1'b0;
    fifo_wr_data_d = fifo_wr_data_q;
    fifo_wr_inc_d  = 1'b0;
    tx_byte_d      = tx_byte_q;
    result_d       = result_q;
    case (state_q)
      IDLE: begin
        if (RX_D_VLD) begin
          case (RX_P_DATA)
            CMD_WR:      state_d = WR_ADDR;
            CMD_RD:      state_d = RD_ADDR;
            CMD_ALU_OP:  state_d = OP_A;
            CMD_ALU_NOP: state_d = ALU_FN;
            default: begin
`ifdef SYS_CTRL_BAD_CMD_ECHO_EN
              tx_byte_d = BAD_CMD_ECHO;
              state_d   = TX_BYTE;
`else
              state_d   = IDLE;
`endif
            end
          endcase
        end
      end
      WR_ADDR: begin
        if (RX_D_VLD) begin
          rf_addr_d = RX_P_DATA[ADDR_WIDTH-1:0];
          state_d   = WR_DATA;
        end
      end
      WR_DATA: begin
        if (RX_D_VLD) begin
          rf_wr_data_d = RX_P_DATA;
          rf_wr_en_d   = 1'b1;
          state_d      = IDLE;
        end
      end
      RD_ADDR: begin
        if (RX_D_VLD) begin
          rf_addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
          rf_rd_en_d = 1'b1;
          state_d    = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (RF_RD_DATA_VLD) begin
          tx_byte_d = RF_RD_DATA;
          state_d   = TX_BYTE;
        end
      end
      OP_A: begin
        if (RX_D_VLD) begin
          rf_addr_d    = ADDR_WIDTH'(0);
          rf_wr_data_d = RX_P_DATA;
          rf_wr_en_d   = 1'b1;
          state_d      = OP_B;
        end
      end
      OP_B: begin
        if (RX_D_VLD) begin
          rf_addr_d    = ADDR_WIDTH'(1);
          rf_wr_data_d = RX_P_DATA;
          rf_wr_en_d   = 1'b1;
          state_d      = ALU_FN;
        end
      end
      ALU_FN: begin
        if (RX_D_VLD) begin
          alu_func_d   = RX_P_DATA[FUNC_WIDTH-1:0];
          alu_en_d     = 1'b1;
          alu_clk_en_d = 1'b1;
          state_d      = ALU_WAIT;
        end
      end
      ALU_WAIT: begin
        // Clock enable is still high during the result cycle and drops right after it.
        alu_clk_en_d = !ALU_OUT_VLD;
        if (ALU_OUT_VLD) begin
          result_d = ALU_OUT;
          state_d  = TX_LO;
        end
      end
      TX_BYTE: begin
        fifo_wr_data_d = tx_byte_q;
        if (can_push) begin
          fifo_wr_inc_d = 1'b1;
          state_d       = IDLE;
        end
      end
      TX_LO: begin
        fifo_wr_data_d = result_q[DATA_WIDTH-1:0];
        if (can_push) begin
          fifo_wr_inc_d = 1'b1;
          state_d       = TX_HI;
        end
      end
      TX_HI: begin
        fifo_wr_data_d = result_q[2*DATA_WIDTH-1:DATA_WIDTH];
        if (can_push) begin
          fifo_wr_inc_d = 1'b1;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q        <= IDLE;
      rf_addr_q      <= '0;
      rf_wr_data_q   <= '0;
      rf_wr_en_q     <= 1'b0;
      rf_rd_en_q     <= 1'b0;
      alu_func_q     <= '0;
      alu_en_q       <= 1'b0;
      alu_clk_en_q   <= 1'b0;
      fifo_wr_data_q <= '0;
      fifo_wr_inc_q  <= 1'b0;
      tx_byte_q      <= '0;
      result_q       <= '0;
    end else begin
      state_q        <= state_d;
      rf_addr_q      <= rf_addr_d;
      rf_wr_data_q   <= rf_wr_data_d;
      rf_wr_en_q     <= rf_wr_en_d;
      rf_rd_en_q     <= rf_rd_en_d;
      alu_func_q     <= alu_func_d;
      alu_en_q       <= alu_en_d;
      alu_clk_en_q   <= alu_clk_en_d;
      fifo_wr_data_q <= fifo_wr_data_d;
      fifo_wr_inc_q  <= fifo_wr_inc_d;
      tx_byte_q      <= tx_byte_d;
      result_q       <= result_d;
    end
  end

  assign RF_ADDR      = rf_addr_q;
  assign RF_WR_DATA   = rf_wr_data_q;
  assign RF_WR_EN     = rf_wr_en_q;
  assign RF_RD_EN     = rf_rd_en_q;
  assign ALU_FUNC     = alu_func_q;
  assign ALU_EN       = alu_en_q;
  assign ALU_CLK_EN   = alu_clk_en_q;
  assign FIFO_WR_DATA = fifo_wr_data_q;
  assign FIFO_WR_INC  = fifo_wr_inc_q;

endmodule
